// File: rtl/da_convert.sv
// Expands a 1-bit-per-pixel bitmap into 8-bit gray SRAM words, two pixels per word.
// Optional macro DA_CONVERT_INVERT_EN adds i_invert to swap FG/BG for a whole frame.
module da_convert #(
  parameter int         N_ROWS  = 160,
  parameter int         N_WORDS = 80,
  parameter logic [7:0] FG      = 8'hFF,
  parameter logic [7:0] BG      = 8'h00
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [19:0] i_begin_addr,
`ifdef DA_CONVERT_INVERT_EN
  input  logic        i_invert,
`endif
  output logic [7:0]  o_row,
  output logic [7:0]  o_column,
  input  logic [1:0]  i_data,
  output logic [19:0] o_sram_addr,
  output logic [15:0] o_sram_data,
  output logic        o_sram_we,
  input  logic        i_sram_ready,
  output logic        o_finished
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    DATA  = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [7:0]  row_r;
  logic [6:0]  word_r;
  logic        accept_s;
  logic        last_s;
  logic        invert_s;

`ifdef DA_CONVERT_INVERT_EN
  logic        invert_r;
  assign invert_s = invert_r;
`else
  assign invert_s = 1'b0;
`endif

  function automatic logic [7:0] map_pixel(input logic pix, input logic inv);
    return (pix ^ inv) ? FG : BG;
  endfunction

  assign accept_s = (state_r == WRITE) && i_sram_ready;
  assign last_s   = (row_r == 8'(N_ROWS - 1)) && (word_r == 7'(N_WORDS - 1));
  assign o_row    = row_r;
  assign o_column = {word_r, 1'b0};

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; i_start outside IDLE has no effect
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (i_start) begin
          state_s = ADDR;
        end else begin
          state_s = IDLE;
        end
      end
      ADDR:  state_s = DATA;
      DATA:  state_s = WRITE;
      WRITE: begin
        if (accept_s) begin
          state_s = last_s ? IDLE : ADDR;
        end else begin
          state_s = WRITE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Counters, address and registered write outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      row_r       <= 8'd0;
      word_r      <= 7'd0;
      o_sram_addr <= 20'd0;
      o_sram_data <= 16'd0;
      o_sram_we   <= 1'b0;
      o_finished  <= 1'b1;
`ifdef DA_CONVERT_INVERT_EN
      invert_r    <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (i_start) begin
            o_sram_addr <= i_begin_addr;
            row_r       <= 8'd0;
            word_r      <= 7'd0;
`ifdef DA_CONVERT_INVERT_EN
            invert_r    <= i_invert;
`endif
          end
        end
        DATA: begin
          o_sram_data <= {map_pixel(i_data[1], invert_s), map_pixel(i_data[0], invert_s)};
        end
        WRITE: begin
          if (accept_s) begin
            o_sram_addr <= o_sram_addr + 20'd1;
            if (word_r == 7'(N_WORDS - 1)) begin
              word_r <= 7'd0;
              row_r  <= row_r + 8'd1;
            end else begin
              word_r <= word_r + 7'd1;
            end
          end
        end
        default: begin
        end
      endcase
      o_sram_we  <= (state_s == WRITE);
      o_finished <= (state_s == IDLE);
    end
  end

endmodule

// File: tb/tb_da_convert.sv
// Directed self-checking bench for da_convert: full frame, row wrap, stall, mid-frame start, reset.
// Exercises the inverted mapping too when DA_CONVERT_INVERT_EN is defined.
module tb_da_convert;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_start = 1'b0;
  logic [19:0] i_begin_addr = 20'd0;
  logic        i_invert = 1'b0;
  logic [7:0]  o_row;
  logic [7:0]  o_column;
  logic [1:0]  i_data;
  logic [19:0] o_sram_addr;
  logic [15:0] o_sram_data;
  logic        o_sram_we;
  logic        i_sram_ready = 1'b0;
  logic        o_finished;

  int          n_checks = 0;
  int          n_fail = 0;
  int          n_wr = 0;
  int          contig_err = 0;
  int          idle_wr_err = 0;
  logic [19:0] frame_base = 20'd0;
  logic [19:0] first_addr, last_addr;
  logic [15:0] first_data, last_data, data79;
  logic        mark_w79 = 1'b0;

  da_convert dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_begin_addr (i_begin_addr),
`ifdef DA_CONVERT_INVERT_EN
    .i_invert     (i_invert),
`endif
    .o_row        (o_row),
    .o_column     (o_column),
    .i_data       (i_data),
    .o_sram_addr  (o_sram_addr),
    .o_sram_data  (o_sram_data),
    .o_sram_we    (o_sram_we),
    .i_sram_ready (i_sram_ready),
    .o_finished   (o_finished)
  );

  always #5 i_clk = ~i_clk;

  // Bitmap source: 2'b10 everywhere, optionally 2'b01 at row 0 word 79
  assign i_data = (mark_w79 && o_row == 8'd0 && o_column == 8'd158) ? 2'b01 : 2'b10;

  // Write monitor: a write is accepted at the posedge following this negedge
  always @(negedge i_clk) begin
    if (o_sram_we && o_finished) idle_wr_err++;
    if (o_sram_we && i_sram_ready && !i_rst) begin
      if (n_wr == 0) begin
        first_addr = o_sram_addr;
        first_data = o_sram_data;
      end else if (o_sram_addr != last_addr + 20'd1) begin
        contig_err++;
      end
      if (o_sram_addr == frame_base + 20'd79) data79 = o_sram_data;
      last_addr = o_sram_addr;
      last_data = o_sram_data;
      n_wr++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_we(input string tag, input int max_cyc);
    int c = 0;
    while (!o_sram_we && c < max_cyc) begin
      @(negedge i_clk);
      c++;
    end
    chk(tag, {31'd0, o_sram_we}, 32'd1);
  endtask

  task automatic wait_row(input string tag, input logic [7:0] row, input int max_cyc);
    int c = 0;
    while (o_row != row && c < max_cyc) begin
      @(negedge i_clk);
      c++;
    end
    chk(tag, {24'd0, o_row}, {24'd0, row});
  endtask

  task automatic start_frame(input logic [19:0] base, input logic rdy);
    @(posedge i_clk); #1;
    n_wr = 0;
    frame_base = base;
    i_begin_addr = base;
    i_sram_ready = rdy;
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
  endtask

  initial begin
    int   cyc;
    logic injected;
    logic cap;
    logic [7:0] row_after, col_after;

    // Reset values
    @(negedge i_clk);
    chk("rst_row", {24'd0, o_row}, 32'd0);
    chk("rst_col", {24'd0, o_column}, 32'd0);
    chk("rst_addr", {12'd0, o_sram_addr}, 32'd0);
    chk("rst_data", {16'd0, o_sram_data}, 32'd0);
    chk("rst_we", {31'd0, o_sram_we}, 32'd0);
    chk("rst_fin", {31'd0, o_finished}, 32'd1);
    @(posedge i_clk); #1;
    i_rst = 1'b0;

    // Full frame with one marked word and a mid-frame start pulse at row 50
    mark_w79 = 1'b1;
    start_frame(20'h01000, 1'b1);
    cyc = 0;
    injected = 1'b0;
    cap = 1'b0;
    row_after = 8'hEE;
    col_after = 8'hEE;
    forever begin
      @(negedge i_clk);
      if (!cap && n_wr == 80 && !o_sram_we) begin
        row_after = o_row;
        col_after = o_column;
        cap = 1'b1;
      end
      if (o_finished || cyc >= 40000) break;
      @(posedge i_clk); #1;
      cyc++;
      if (!injected && o_row == 8'd50) begin
        i_start = 1'b1;
        i_begin_addr = 20'h00000;
        injected = 1'b1;
      end else begin
        i_start = 1'b0;
      end
    end
    mark_w79 = 1'b0;
    chk("frame_cycles", cyc, 32'd38400);
    chk("frame_words", n_wr, 32'd12800);
    chk("first_addr", {12'd0, first_addr}, 32'h01000);
    chk("first_data", {16'd0, first_data}, 32'hFF00);
    chk("w79_data", {16'd0, data79}, 32'h00FF);
    chk("wrap_row", {24'd0, row_after}, 32'd1);
    chk("wrap_col", {24'd0, col_after}, 32'd0);
    chk("last_addr", {12'd0, last_addr}, 32'h041FF);
    chk("last_data", {16'd0, last_data}, 32'hFF00);
    chk("contiguous", contig_err, 32'd0);
    chk("start_seen_r50", {31'd0, injected}, 32'd1);
    chk("fin_after", {31'd0, o_finished}, 32'd1);
    chk("we_after", {31'd0, o_sram_we}, 32'd0);

    // Write stall: outputs hold for 5 cycles, one write on release
    start_frame(20'h80000, 1'b0);
    @(negedge i_clk);
    chk("busy_fin", {31'd0, o_finished}, 32'd0);
    wait_we("stall_we_wait", 10);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge i_clk);
      chk("stall_we", {31'd0, o_sram_we}, 32'd1);
      chk("stall_addr", {12'd0, o_sram_addr}, 32'h80000);
      chk("stall_data", {16'd0, o_sram_data}, 32'hFF00);
    end
    @(posedge i_clk); #1;
    i_sram_ready = 1'b1;
    @(posedge i_clk); #1;
    i_sram_ready = 1'b0;
    @(negedge i_clk);
    chk("stall_one_wr", n_wr, 32'd1);
    chk("stall_next_addr", {12'd0, o_sram_addr}, 32'h80001);
    chk("stall_col", {24'd0, o_column}, 32'd2);

    // Reset during a write stall at row 10
    @(posedge i_clk); #1;
    i_sram_ready = 1'b1;
    wait_row("reach_row10", 8'd10, 5000);
    @(posedge i_clk); #1;
    i_sram_ready = 1'b0;
    wait_we("r10_we_wait", 10);
    @(negedge i_clk);
    chk("r10_stalled", {31'd0, o_sram_we}, 32'd1);
    #2 i_rst = 1'b1;
    #1;
    chk("arst_we", {31'd0, o_sram_we}, 32'd0);
    chk("arst_fin", {31'd0, o_finished}, 32'd1);
    chk("arst_row", {24'd0, o_row}, 32'd0);
    #1 i_rst = 1'b0;

    // Restart after reset begins at row 0 word 0
    start_frame(20'h00010, 1'b1);
    @(negedge i_clk);
    chk("restart_row", {24'd0, o_row}, 32'd0);
    chk("restart_col", {24'd0, o_column}, 32'd0);
    for (int c = 0; c < 20 && n_wr < 2; c++) @(negedge i_clk);
    chk("restart_first_addr", {12'd0, first_addr}, 32'h00010);
    chk("restart_first_data", {16'd0, first_data}, 32'hFF00);
    chk("no_idle_write", idle_wr_err, 32'd0);

`ifdef DA_CONVERT_INVERT_EN
    // Inverted mapping for a whole frame
    i_rst = 1'b1;
    #2 i_rst = 1'b0;
    i_invert = 1'b1;
    start_frame(20'h00200, 1'b1);
    i_invert = 1'b0;
    for (int c = 0; c < 20 && n_wr < 2; c++) @(negedge i_clk);
    chk("invert_data", {16'd0, first_data}, 32'h00FF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
